// File: rtl/conv_pkg.sv
// Purpose: shared constants for the convolution datapath (loader, weight_register, convolver).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

   // Loader controller state encoding
   localparam logic [1:0] FILL    = 2'd0;
   localparam logic [1:0] PENDING = 2'd1;
   localparam logic [1:0] COMMIT  = 2'd2;

   // Default kernel geometry shared by weight_register and the convolver
   localparam int KERNEL_N     = 9;
   localparam int WEIGHT_WIDTH = 16;

endpackage

// File: rtl/weight_shadow_buffer.sv
// Purpose: N-slot shadow array; one indexed word write per cycle, all slots visible as a flat bus.
// Latency: a word written at edge E appears on data_o right after E.
// Backpressure: none; always accepts the write it is given.
// Ports: clock/reset (async active-low), wr_en_i/wr_idx_i/wr_dat_i write port,
//        data_o flattened slots, slot k at [k*DATA_WIDTH +: DATA_WIDTH].
module weight_shadow_buffer
   import conv_pkg::*;
#(
   parameter int N          = KERNEL_N,
   parameter int DATA_WIDTH = WEIGHT_WIDTH,
   parameter int IDX_WIDTH  = $clog2(N + 2)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en_i,
   input  logic [IDX_WIDTH-1:0]    wr_idx_i,
   input  logic [DATA_WIDTH-1:0]   wr_dat_i,
   output logic [N*DATA_WIDTH-1:0] data_o
);

   logic [DATA_WIDTH-1:0] slot_q [N];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            slot_q[k] <= '0;
         end
      end else if (wr_en_i) begin
         for (int k = 0; k < N; k++) begin
            if (wr_idx_i == IDX_WIDTH'(k)) begin
               slot_q[k] <= wr_dat_i;
            end
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_flat
      assign data_o[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
   end

endmodule

// File: rtl/weight_loader.sv
// Purpose: collects N weight words into a shadow buffer and commits them to weight_register when the convolver is idle.
// Latency: write strobe 2 cycles after the last word is accepted (longer while conv_busy holds it in PENDING).
// Backpressure: s_ready low outside FILL, during clear and during reset; no words are taken while a kernel awaits commit.
// Ports: clock, reset (async active-low), clear (sync abort), s_valid/s_data/s_ready word stream,
//        conv_busy commit gate, write + weight_write to weight_register, fill_count, loaded, error.
// Optional: WEIGHT_LOADER_CHECKSUM_EN adds a trailing checksum word (sum of weights mod 2^DATA_WIDTH);
//           a mismatch pulses error and discards the kernel. Undefined: error is tied low.
module weight_loader
   import conv_pkg::*;
#(
   parameter  int N          = KERNEL_N,
   parameter  int DATA_WIDTH = WEIGHT_WIDTH,
   localparam int CNT_WIDTH  = $clog2(N + 2)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    s_valid,
   input  logic [DATA_WIDTH-1:0]   s_data,
   output logic                    s_ready,
   input  logic                    conv_busy,
   output logic                    write,
   output logic [N*DATA_WIDTH-1:0] weight_write,
   output logic [CNT_WIDTH-1:0]    fill_count,
   output logic                    loaded,
   output logic                    error
);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   localparam int LAST_IDX = N;      // checksum word follows the N weights
`else
   localparam int LAST_IDX = N - 1;
`endif
   localparam logic [CNT_WIDTH-1:0] LAST  = CNT_WIDTH'(LAST_IDX);
   localparam logic [CNT_WIDTH-1:0] NSLOT = CNT_WIDTH'(N);

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 loaded_q, loaded_d;
   logic                 accept;
   logic                 wr_en;
   logic                 csum_bad;

   assign accept = s_valid && s_ready;
   // Only weight words land in the buffer; the checksum word is not stored.
   assign wr_en  = accept && (cnt_q < NSLOT);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic                  err_q, err_d;

   assign csum_bad = (s_data != sum_q);

   // Restarting the sum on word 0 avoids clearing it on every path back to FILL.
   always_comb begin
      sum_d = sum_q;
      if (wr_en) begin
         sum_d = (cnt_q == '0) ? s_data : sum_q + s_data;
      end
   end

   assign err_d = accept && (cnt_q == LAST) && csum_bad;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end

   assign error = err_q;
`else
   assign csum_bad = 1'b0;
   assign error    = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         loaded_q <= loaded_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      loaded_d = loaded_q;
      case (state_q)
         FILL: begin
            if (clear) begin
               cnt_d    = '0;
               loaded_d = 1'b0;
            end else if (accept) begin
               if (cnt_q == LAST) begin
                  if (csum_bad) begin
                     cnt_d = '0;
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     state_d = PENDING;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PENDING: begin
            if (clear) begin
               state_d  = FILL;
               cnt_d    = '0;
               loaded_d = 1'b0;
            end else if (!conv_busy) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            // The strobe always completes; a clear seen here lands on the exit edge.
            state_d  = FILL;
            cnt_d    = '0;
            loaded_d = !clear;
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs
   always_comb begin
      s_ready = (state_q == FILL) && !clear && reset;
      write   = (state_q == COMMIT);
   end

   assign fill_count = cnt_q;
   assign loaded     = loaded_q;

   weight_shadow_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (CNT_WIDTH)
   ) u_shadow (
      .clock    (clock),
      .reset    (reset),
      .wr_en_i  (wr_en),
      .wr_idx_i (cnt_q),
      .wr_dat_i (s_data),
      .data_o   (weight_write)
   );

endmodule

// File: tb/tb_weight_loader.sv
// Purpose: directed, table-driven bench for weight_loader (N=9, DATA_WIDTH=16, 20 ns clock).
// Latency: each table row is one clock cycle; outputs are sampled 1 ns after the falling-edge drive.
// Backpressure: rows carry the expected s_ready for that cycle.
module tb_weight_loader;

   localparam int N  = 9;
   localparam int DW = 16;
   localparam int CW = $clog2(N + 2);
   localparam int WW = N * DW;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          clear;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          conv_busy;
   logic          write;
   logic [WW-1:0] weight_write;
   logic [CW-1:0] fill_count;
   logic          loaded;
   logic          error;

   weight_loader #(.N(N), .DATA_WIDTH(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .clear        (clear),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .conv_busy    (conv_busy),
      .write        (write),
      .weight_write (weight_write),
      .fill_count   (fill_count),
      .loaded       (loaded),
      .error        (error)
   );

   always #10 clock = ~clock;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          busy;
      logic          clr;
      logic          e_rdy;
      logic          e_wr;
      int            e_cnt;
      logic          e_ld;
      logic          chk_ww;
      logic [WW-1:0] e_ww;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input int row, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic push(input logic v, input logic [DW-1:0] d, input logic busy, input logic clr,
                       input logic rdy, input logic wr, input int cnt, input logic ld,
                       input logic chkww, input logic [WW-1:0] ww);
      vec_t r;
      r.v = v; r.d = d; r.busy = busy; r.clr = clr;
      r.e_rdy = rdy; r.e_wr = wr; r.e_cnt = cnt; r.e_ld = ld;
      r.chk_ww = chkww; r.e_ww = ww;
      vecs.push_back(r);
   endtask

   function automatic logic [WW-1:0] pack(input logic [DW-1:0] first);
      logic [WW-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) begin
         r[k*DW +: DW] = first + DW'(k);
      end
      return r;
   endfunction

   // Rows for one full fill: words first..first+N-1 (plus checksum word when enabled).
   task automatic add_fill(input logic [DW-1:0] first, input logic gaps, input logic busy, input logic ld);
      logic [DW-1:0] sum;
      logic [DW-1:0] w;
      sum = '0;
      for (int k = 0; k < N + EXTRA; k++) begin
         w = (k < N) ? first + DW'(k) : sum;
         if (k < N) sum = sum + w;
         push(1'b1, w, busy, 1'b0, 1'b1, 1'b0, k, ld, 1'b0, '0);
         if (gaps && (k < N + EXTRA - 1)) begin
            push(1'b0, 16'hDEAD, busy, 1'b0, 1'b1, 1'b0, k + 1, ld, 1'b0, '0);
         end
      end
   endtask

   // Rows from PENDING through the strobe and back into FILL.
   task automatic add_commit(input int busy_cyc, input logic ld_before, input logic [WW-1:0] ww, input logic ld_after);
      for (int k = 0; k < busy_cyc; k++) begin
         push(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, N + EXTRA, ld_before, 1'b0, '0);
      end
      push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, N + EXTRA, ld_before, 1'b0, '0);
      push(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, N + EXTRA, ld_before, 1'b1, ww);
      push(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0, ld_after, 1'b1, ww);
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d, input logic busy, input logic clr);
      @(negedge clock);
      s_valid   = v;
      s_data    = d;
      conv_busy = busy;
      clear     = clr;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] sum;
      logic [DW-1:0] w;
      int            waited;

      // ---------------- reset ----------------
      reset = 1'b0; clear = 1'b0; s_valid = 1'b1; s_data = 16'h1234; conv_busy = 1'b0;
      #50;
      chk("rst_s_ready", -1, WW'(s_ready), '0);
      chk("rst_write", -1, WW'(write), '0);
      chk("rst_fill_count", -1, WW'(fill_count), '0);
      chk("rst_weight_write", -1, weight_write, '0);
      chk("rst_loaded", -1, WW'(loaded), '0);
      chk("rst_error", -1, WW'(error), '0);
      #50;
      reset = 1'b1; s_valid = 1'b0;

      // ---------------- table ----------------
      // back-to-back 0x0001..0x0009, no busy
      add_fill(16'h0001, 1'b0, 1'b0, 1'b0);
      add_commit(0, 1'b0, pack(16'h0001), 1'b1);
      // busy held during fill and 5 cycles of PENDING
      add_fill(16'h0011, 1'b0, 1'b1, 1'b1);
      add_commit(5, 1'b1, pack(16'h0011), 1'b1);
      // partial fill of 0xAAAA, clear (s_valid high, must be ignored), then fresh fill
      for (int k = 0; k < 4; k++) begin
         push(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, k, 1'b1, 1'b0, '0);
      end
      push(1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, '0);
      add_fill(16'h0010, 1'b0, 1'b0, 1'b0);
      add_commit(0, 1'b0, pack(16'h0010), 1'b1);
      // s_valid toggling every other cycle
      add_fill(16'h0100, 1'b1, 1'b0, 1'b1);
      add_commit(0, 1'b1, pack(16'h0100), 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].d, vecs[i].busy, vecs[i].clr);
         chk("s_ready", i, WW'(s_ready), WW'(vecs[i].e_rdy));
         chk("write", i, WW'(write), WW'(vecs[i].e_wr));
         chk("fill_count", i, WW'(fill_count), WW'(vecs[i].e_cnt));
         chk("loaded", i, WW'(loaded), WW'(vecs[i].e_ld));
         chk("error", i, WW'(error), '0);
         if (vecs[i].chk_ww) begin
            chk("weight_write", i, weight_write, vecs[i].e_ww);
         end
      end

      // ---------------- asynchronous reset mid-fill ----------------
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 16'h0300 + DW'(k), 1'b0, 1'b0);
      end
      step(1'b0, '0, 1'b0, 1'b0);
      chk("mid_pre_count", 100, WW'(fill_count), WW'(5));
      #4 reset = 1'b0;
      #1;
      chk("mid_fill_count", 100, WW'(fill_count), '0);
      chk("mid_weight_write", 100, weight_write, '0);
      chk("mid_write", 100, WW'(write), '0);
      chk("mid_s_ready", 100, WW'(s_ready), '0);
      chk("mid_loaded", 100, WW'(loaded), '0);
      @(negedge clock);
      reset = 1'b1;

      // fresh fill after reset release
      sum = '0;
      for (int k = 0; k < N + EXTRA; k++) begin
         w = (k < N) ? 16'h0201 + DW'(k) : sum;
         if (k < N) sum = sum + w;
         step(1'b1, w, 1'b0, 1'b0);
      end
      waited = 0;
      do begin
         step(1'b0, '0, 1'b0, 1'b0);
         waited++;
      end while (!write && waited < 6);
      chk("fresh_latency", 101, WW'(waited), WW'(2));
      chk("fresh_write", 101, WW'(write), WW'(1));
      chk("fresh_weight_write", 101, weight_write, pack(16'h0201));
      step(1'b0, '0, 1'b0, 1'b0);
      chk("fresh_write_drop", 102, WW'(write), '0);
      chk("fresh_loaded", 102, WW'(loaded), WW'(1));

`ifdef WEIGHT_LOADER_CHECKSUM_EN
      // ---------------- checksum mismatch ----------------
      for (int k = 0; k < N; k++) begin
         step(1'b1, 16'h0001 + DW'(k), 1'b0, 1'b0);
      end
      step(1'b1, 16'h002C, 1'b0, 1'b0);
      chk("cs_pre_count", 200, WW'(fill_count), WW'(N));
      step(1'b0, '0, 1'b0, 1'b0);
      chk("cs_error", 201, WW'(error), WW'(1));
      chk("cs_write", 201, WW'(write), '0);
      chk("cs_fill_count", 201, WW'(fill_count), '0);
      chk("cs_s_ready", 201, WW'(s_ready), WW'(1));
      chk("cs_loaded", 201, WW'(loaded), WW'(1));
      for (int k = 0; k < 3; k++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         chk("cs_error_drop", 202 + k, WW'(error), '0);
         chk("cs_no_write", 202 + k, WW'(write), '0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
